// File: rtl/display_scan_decoder.sv
// Four-digit multiplexed 7-segment driver for the microwave MM:SS timer.
// Latches BCD digits, scans them onto a shared bus, with blanking, colon and blink.
module display_scan_decoder #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    input  logic        colon_en,
    input  logic        blink_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_HIDDEN  = 1'b1
    } phase_t;

    logic [15:0]   shadow_q, shadow_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blinkCnt_q, blinkCnt_d;
    phase_t        phase_q, phase_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          frameTick_q, frameTick_d;

    logic       scanWrap;
    logic       frameWrap;
    logic       hidden;
    logic       blankD3;
    logic       blankD2;
    logic       slotBlank;
    logic [3:0] digit;

    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '0;
            prescaler_q <= '0;
            idx_q       <= '0;
            blinkCnt_q  <= '0;
            phase_q     <= PHASE_VISIBLE;
            seg_q       <= 7'h7F;
            an_q        <= 4'hF;
            dp_q        <= 1'b1;
            frameTick_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            blinkCnt_q  <= blinkCnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
            frameTick_q <= frameTick_d;
        end
    end

    always_comb begin
        scanWrap    = (prescaler_q == PW'(SCAN_DIV - 1));
        frameWrap   = scanWrap && (idx_q == 2'd3);
        prescaler_d = scanWrap ? '0 : prescaler_q + 1'b1;
        idx_d       = scanWrap ? idx_q + 2'd1 : idx_q;
        frameTick_d = frameWrap;
        shadow_d    = load ? bcd_in : shadow_q;

        // Dropping blink_en restarts the blink cadence from a visible phase.
        blinkCnt_d = blinkCnt_q;
        phase_d    = phase_q;
        if (!blink_en) begin
            blinkCnt_d = '0;
            phase_d    = PHASE_VISIBLE;
        end else if (frameWrap) begin
            if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
                blinkCnt_d = '0;
                phase_d    = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
            end else begin
                blinkCnt_d = blinkCnt_q + 1'b1;
            end
        end

        digit   = shadow_q[3:0];
        case (idx_q)
            2'd0: digit = shadow_q[3:0];
            2'd1: digit = shadow_q[7:4];
            2'd2: digit = shadow_q[11:8];
            2'd3: digit = shadow_q[15:12];
            default: digit = shadow_q[3:0];
        endcase

        // Minute-units only blanks when minute-tens is already blank.
        blankD3   = blank_lz && (shadow_q[15:12] == 4'd0);
        blankD2   = blankD3 && (shadow_q[11:8] == 4'd0);
        slotBlank = ((idx_q == 2'd3) && blankD3) || ((idx_q == 2'd2) && blankD2);
        hidden    = blink_en && (phase_q == PHASE_HIDDEN);

        seg_d = slotBlank ? 7'h7F : decodeDigit(digit);
        an_d  = ~(4'b0001 << idx_q);
        dp_d  = !((idx_q == 2'd2) && colon_en);
        if (hidden) begin
            seg_d = 7'h7F;
            an_d  = 4'hF;
            dp_d  = 1'b1;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Scoreboard bench for display_scan_decoder with a fast scan (SCAN_DIV=4, BLINK_DIV=2).
// A reference model predicts each cycle's outputs, queued before the edge and popped after.
module tb_display_scan_decoder;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;
    localparam int FRAME_LEN = 4 * SCAN_DIV;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
        logic       ft;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic        colon_en;
    logic        blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    expect_t     scoreboard[$];
    int          checks;
    int          errors;
    int          edgeCount;
    int          framesM;
    logic [15:0] shadowM;

    display_scan_decoder #(
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .bcd_in    (bcd_in),
        .blank_lz  (blank_lz),
        .colon_en  (colon_en),
        .blink_en  (blink_en),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] refSegments(input logic [3:0] d);
        logic [6:0] table10 [10];
        table10 = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (d > 4'd9) return 7'b0111111;
        return table10[d];
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: observed=%h expected=%h", tag, edgeCount, observed, expected);
        end
    endtask

    // Each cycle: predict from model state, clock the DUT, then compare against the popped entry.
    task automatic applyStimulus(input int cycles);
        expect_t exp;
        expect_t got;
        int      slot;
        logic    hid;
        logic    blankSlot;
        for (int c = 0; c < cycles; c++) begin
            slot      = (edgeCount / SCAN_DIV) % 4;
            hid       = blink_en && (((framesM / BLINK_DIV) % 2) == 1);
            blankSlot = blank_lz && (shadowM[15:12] == 4'd0) &&
                        ((slot == 3) || ((slot == 2) && (shadowM[11:8] == 4'd0)));
            exp.ft  = ((edgeCount + 1) % FRAME_LEN) == 0;
            if (hid) begin
                exp.seg = 7'h7F;
                exp.an  = 4'hF;
                exp.dp  = 1'b1;
            end else begin
                exp.seg = blankSlot ? 7'h7F : refSegments(shadowM[slot*4 +: 4]);
                case (slot)
                    0:       exp.an = 4'b1110;
                    1:       exp.an = 4'b1101;
                    2:       exp.an = 4'b1011;
                    default: exp.an = 4'b0111;
                endcase
                exp.dp = (slot == 2 && colon_en) ? 1'b0 : 1'b1;
            end
            scoreboard.push_back(exp);

            @(posedge clk);
            #1;
            if (load) shadowM = bcd_in;
            if (!blink_en) framesM = 0;
            else if (exp.ft) framesM++;
            edgeCount++;

            if (scoreboard.size() == 0) begin
                checkOutput("queue_empty", 16'd1, 16'd0);
            end else begin
                got = scoreboard.pop_front();
                checkOutput("seg", {9'd0, seg}, {9'd0, got.seg});
                checkOutput("an", {12'd0, an}, {12'd0, got.an});
                checkOutput("dp", {15'd0, dp}, {15'd0, got.dp});
                checkOutput("frame_tick", {15'd0, frame_tick}, {15'd0, got.ft});
            end
        end
    endtask

    task automatic pulseReset();
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_seg", {9'd0, seg}, 16'h007F);
        checkOutput("rst_an", {12'd0, an}, 16'h000F);
        checkOutput("rst_dp", {15'd0, dp}, 16'h0001);
        checkOutput("rst_tick", {15'd0, frame_tick}, 16'h0000);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        edgeCount = 0;
        framesM   = 0;
        shadowM   = 16'h0000;
        scoreboard.delete();
    endtask

    task automatic loadDigits(input logic [15:0] value);
        bcd_in = value;
        load   = 1'b1;
        applyStimulus(1);
        load   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'h0000;
        blank_lz = 1'b0;
        colon_en = 1'b0;
        blink_en = 1'b0;
        edgeCount = 0;
        framesM   = 0;
        shadowM   = 16'h0000;

        @(posedge clk);
        #1;
        pulseReset();
        applyStimulus(10);
        pulseReset();
        applyStimulus(20);

        loadDigits(16'h1234);
        applyStimulus(33);

        blank_lz = 1'b1;
        loadDigits(16'h0005);
        applyStimulus(20);
        blank_lz = 1'b0;
        applyStimulus(16);
        blank_lz = 1'b1;
        loadDigits(16'h0105);
        applyStimulus(16);
        blank_lz = 1'b0;

        loadDigits(16'hA9F0);
        applyStimulus(16);

        blink_en = 1'b1;
        pulseReset();
        applyStimulus(100);
        blink_en = 1'b0;
        applyStimulus(10);
        blink_en = 1'b1;
        applyStimulus(40);
        blink_en = 1'b0;

        colon_en = 1'b1;
        loadDigits(16'h1234);
        applyStimulus(16);
        while ((edgeCount % SCAN_DIV) != SCAN_DIV - 1) applyStimulus(1);
        loadDigits(16'h0987);
        applyStimulus(20);
        colon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
